// File: rtl/mesh_terminal_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mesh_terminal_tx                                                 |
// | Purpose  : Host-side packet injector feeding one mesh_gnrtr terminal port:  |
// |            packet assembly, destination filtering, FWFT FIFO and counters.  |
// | Options  : MESH_TX_SEQNUM_EN - stamp payload[7:0] with a sequence number.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module mesh_terminal_tx #(
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4,
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4,
   parameter int ID_ROW     = 0,
   parameter int ID_COL     = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [3:0]                    wr_row,
   input  logic [3:0]                    wr_col,
   input  logic                          wr_mode,
   input  logic [pckg_sz-18:0]           wr_payload,
   output logic                          full,
   output logic                          drop,
   output logic [$clog2(fifo_depth):0]   count,
   output logic [15:0]                   sent_cnt,
   output logic [7:0]                    drop_cnt,
   output logic                          pndng_i_in,
   output logic [pckg_sz-1:0]            data_out_i_in,
   input  logic                          popin
);

   localparam int c_aw = $clog2(fifo_depth);
   localparam int c_cw = c_aw + 1;

   logic [pckg_sz-1:0]  r_mem [fifo_depth];
   logic [c_aw-1:0]     r_wr_ptr;
   logic [c_aw-1:0]     r_rd_ptr;
   logic [c_cw-1:0]     r_count;
   logic                r_drop;
   logic [15:0]         r_sent_cnt;
   logic [7:0]          r_drop_cnt;

   logic                w_bad_dest;
   logic                w_reject;
   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic [pckg_sz-18:0] w_payload;
   logic [pckg_sz-1:0]  w_packet;

   // Destinations beyond the mesh edge ring, or this terminal itself, are unroutable.
   assign w_bad_dest = ({28'd0, wr_row} > 32'(ROWS + 1))
                     | ({28'd0, wr_col} > 32'(COLUMS + 1))
                     | ((wr_row == 4'(ID_ROW)) && (wr_col == 4'(ID_COL)));

   assign w_reject = wr_en & w_bad_dest;
   assign w_full   = (r_count == c_cw'(fifo_depth));
   assign w_push   = wr_en & ~w_bad_dest & ~w_full;
   assign w_pop    = popin & (r_count != '0);

`ifdef MESH_TX_SEQNUM_EN
   logic [7:0] r_seq;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seq <= 8'd0;
      end else if (w_push) begin
         r_seq <= r_seq + 8'd1;
      end
   end

   always_comb begin
      w_payload      = wr_payload;
      w_payload[7:0] = r_seq;
   end
`else
   assign w_payload = wr_payload;
`endif

   assign w_packet = {8'd0, wr_row, wr_col, wr_mode, w_payload};

   // Storage carries no reset; stale entries are masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_packet;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop     <= 1'b0;
         r_sent_cnt <= 16'd0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_drop <= w_reject;
         if (w_reject && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_sent_cnt <= r_sent_cnt + 16'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign full          = w_full;
   assign drop          = r_drop;
   assign count         = r_count;
   assign sent_cnt      = r_sent_cnt;
   assign drop_cnt      = r_drop_cnt;
   assign pndng_i_in    = (r_count != '0);
   assign data_out_i_in = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: doc/mesh_terminal_tx.md
# mesh_terminal_tx

Terminal-side packet injector for the mesh router network. It accepts destination and payload fields from a host port and assembles them into mesh packets. Packets are buffered in a first-word-fall-through FIFO and presented to one mesh terminal input through the `pndng_i_in` / `data_out_i_in` / `popin` handshake. One instance sits directly upstream of each terminal port of `mesh_gnrtr`. The block also rejects unroutable destinations and keeps sent and dropped counters for the scoreboard.

## Interface
- `ROWS`, default 4: mesh rows.
- `COLUMS`, default 4: mesh columns.
- `pckg_sz`, default 40: packet width in bits; must be at least 25.
- `fifo_depth`, default 4: buffer entries; must be a power of two, at least 2.
- `ID_ROW`, default 0: row address of this terminal.
- `ID_COL`, default 1: column address of this terminal.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  host write request.
- `wr_row`  in  4  destination row.
- `wr_col`  in  4  destination column.
- `wr_mode`  in  1  routing mode bit, copied into the packet.
- `wr_payload`  in  pckg_sz-17  payload.
- `full`  out  1  FIFO holds `fifo_depth` entries.
- `drop`  out  1  one-cycle pulse: the previous write was rejected.
- `count`  out  $clog2(fifo_depth)+1  current occupancy.
- `sent_cnt`  out  16  packets popped by the router; wraps.
- `drop_cnt`  out  8  rejected writes; saturates at 255.
- `pndng_i_in`  out  1  head packet valid toward the router.
- `data_out_i_in`  out  pckg_sz  head packet.
- `popin`  in  1  router consumes the head packet.

## Operation
- Packet layout:
  - [pckg_sz-1 -: 8]: next-jump field, forced to 0.
  - [pckg_sz-9 -: 4]: `wr_row`.
  - [pckg_sz-13 -: 4]: `wr_col`.
  - [pckg_sz-17]: `wr_mode`.
  - [pckg_sz-18:0]: payload.
- Write qualification: a write is attempted when `wr_en`=1. It is:
  - Rejected (dropped) if `wr_row` > ROWS+1, or `wr_col` > COLUMS+1, or {`wr_row`,`wr_col`} equals {ID_ROW,ID_COL}.
  - Ignored, with no drop, if `full`=1. The host must hold the write until `full` falls.
  - Accepted otherwise: written at the write pointer, then the pointer increments modulo `fifo_depth`.
- Drops: each rejected write raises `drop` for exactly the next cycle and increments `drop_cnt`, which saturates at 255.
- Pop: when `popin`=1 and `count`>0, the read pointer increments and `sent_cnt` increments (wrapping at 16 bits). `popin` while empty has no effect.
- Simultaneous push and pop with 0<`count`<`fifo_depth`: `count` is unchanged and both pointers advance.
- Simultaneous push and pop with `count`=0: the push lands and `count` becomes 1. The pop has no effect.
- Simultaneous push and pop with `full`=1: the push is refused and the pop proceeds.
- Head output:
  - `pndng_i_in` = (`count`!=0).
  - `data_out_i_in` = the FIFO entry at the read pointer when `count`!=0, else all zeros.
- Reset, asserted at any time: pointers, `count`, `sent_cnt`, `drop_cnt`, `drop` and the sequence counter clear to 0. All buffered packets are discarded. `pndng_i_in`=0 and `data_out_i_in`=0 while `reset`=0.

## Timing
- Write to `pndng_i_in` on an empty FIFO: 1 cycle. `pndng_i_in` is high in the cycle after the accepting edge.
- `data_out_i_in` is valid in the same cycle as `pndng_i_in`. It is stable until the edge at which `popin`=1.
- Pop to next head: the next entry appears in the cycle after the popping edge. Back-to-back pops drain one packet per cycle.
- `full` and `count` update at the same edge as the push or pop.
- `drop` is registered and rises one cycle after the rejected `wr_en`.
- The first write after reset release is accepted at the first rising edge with `reset`=1.

## Configuration
- `MESH_TX_SEQNUM_EN` defined:
  - An 8-bit sequence counter overwrites payload bits [7:0] of every accepted packet.
  - The counter increments once per accepted write and wraps 255→0. Rejected and ignored writes do not advance it.
- `MESH_TX_SEQNUM_EN` undefined: payload passes through unmodified and no sequence counter exists.

## Test plan
- Reset, then write row=0, col=2, mode=1, payload=23'h1234 with ID (0,1): one cycle later `pndng_i_in`=1 and `data_out_i_in`=40'h00_0_2_801234 (row field 0, col field 2, mode bit set). Pulse `popin`: `sent_cnt`=1 and `pndng_i_in`=0.
- Five consecutive writes with `popin`=0 and `fifo_depth`=4: `full`=1 after the 4th, the 5th is ignored, `count`=4, `drop`=0. Drain with 4 pops: payloads come out in write order.
- Write row=6 with ROWS=4, then write row=0/col=1 (own address): `drop` pulses twice, `drop_cnt`=2, `count`=0. Repeat 300 invalid writes: `drop_cnt` holds at 255.
- With `count`=2, assert `wr_en` and `popin` in the same cycle: `count` stays 2 and FIFO order is preserved. With `count`=4, same stimulus: `count` becomes 3 and the write is refused.
- Load 3 packets, assert `reset`=0 between clock edges: `pndng_i_in`, `count` and `sent_cnt` go to 0 immediately. After release the FIFO is empty.
- With `MESH_TX_SEQNUM_EN` defined, make 258 accepted writes interleaved with pops: payload[7:0] runs 0,1,…,255,0,1. Invalid writes do not consume sequence numbers.
